present_stream_ctrl: RTL



---
 rtl/present_pkg.sv | 26 ++
 rtl/present_byte_ser.sv | 44 ++++
 rtl/present_stream_ctrl.sv | 124 ++++++++++++
 3 files changed

// File: rtl/present_pkg.sv
// rtl/present_pkg.sv - constants and state encoding for present_stream_ctrl (PRESENT_KEY_KEEP_EN selects key-keep framing)
package present_pkg;

  localparam int KEY_BYTES = 10;
  localparam int PT_BYTES  = 8;
  localparam int CT_BYTES  = 8;
  localparam int ROUNDS    = 32;

  typedef enum logic [1:0] {
    LOAD      = 2'd0,
    WAIT_SYNC = 2'd1,
    RUN       = 2'd2,
    OUT       = 2'd3
  } state_e;

`ifdef PRESENT_KEY_KEEP_EN
  // Key bytes are tagged separately, so a frame is plaintext only.
  localparam logic [4:0] IN_LAST = 5'(PT_BYTES - 1);
`else
  // Frame carries the key first, then the plaintext.
  localparam logic [4:0] IN_LAST = 5'(KEY_BYTES + PT_BYTES - 1);
`endif
  localparam logic [4:0] KEY_LAST = 5'(KEY_BYTES - 1);
  localparam logic [2:0] OUT_LAST = 3'(CT_BYTES - 1);

endpackage

// File: rtl/present_byte_ser.sv
// rtl/present_byte_ser.sv - 64-bit load, 8-byte valid/ready serializer, most significant byte first
module present_byte_ser
  import present_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_i,
  input  logic [63:0] data_i,
  output logic [7:0]  tdata_o,
  output logic        tvalid_o,
  input  logic        tready_i,
  output logic        done_o
);

  logic [63:0] sreg_q;
  logic [2:0]  cnt_q;
  logic        valid_q;

  // Load the ciphertext word, then shift one byte out per accepted handshake.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sreg_q  <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else if (load_i) begin
      sreg_q  <= data_i;
      cnt_q   <= '0;
      valid_q <= 1'b1;
    end else if (valid_q && tready_i) begin
      sreg_q <= {sreg_q[55:0], 8'h00};
      if (cnt_q == OUT_LAST) begin
        cnt_q   <= '0;
        valid_q <= 1'b0;
      end else begin
        cnt_q <= cnt_q + 3'd1;
      end
    end
  end

  assign tdata_o  = sreg_q[63:56];
  assign tvalid_o = valid_q;
  assign done_o   = valid_q && tready_i && (cnt_q == OUT_LAST);

endmodule

// File: rtl/present_stream_ctrl.sv
// rtl/present_stream_ctrl.sv - byte-stream front end for a PRESENT core; PRESENT_KEY_KEEP_EN adds in_is_key and a retained key
module present_stream_ctrl
  import present_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
`ifdef PRESENT_KEY_KEEP_EN
  input  logic        in_is_key,
`endif
  input  logic        frame_sync,
  output logic [63:0] core_state,
  output logic [79:0] core_keys,
  input  logic [63:0] core_result,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        busy
);

  state_e      state_q;
  logic [4:0]  in_cnt_q;
  logic [63:0] core_state_q;
  logic [79:0] core_keys_q;
  logic        in_ready_q;
  logic        busy_q;
  logic        ser_load;
  logic        ser_done;
  logic        in_fire;

  assign in_fire  = in_valid && in_ready_q;
  // The core result is only valid on the sync cycle that ends RUN.
  assign ser_load = (state_q == RUN) && frame_sync;

  // Frame sequencing: gather bytes, wait for the core's round 0, run, then drain.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= LOAD;
      in_cnt_q     <= '0;
      core_state_q <= '0;
      core_keys_q  <= '0;
      in_ready_q   <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      case (state_q)
        LOAD: begin
          in_ready_q <= 1'b1;
          busy_q     <= 1'b0;
          if (in_fire) begin
`ifdef PRESENT_KEY_KEEP_EN
            if (in_is_key) begin
              core_keys_q <= {core_keys_q[71:0], in_data};
            end else begin
              core_state_q <= {core_state_q[55:0], in_data};
              if (in_cnt_q == IN_LAST) begin
                in_cnt_q   <= '0;
                state_q    <= WAIT_SYNC;
                in_ready_q <= 1'b0;
                busy_q     <= 1'b1;
              end else begin
                in_cnt_q <= in_cnt_q + 5'd1;
              end
            end
`else
            if (in_cnt_q <= KEY_LAST) begin
              core_keys_q <= {core_keys_q[71:0], in_data};
            end else begin
              core_state_q <= {core_state_q[55:0], in_data};
            end
            if (in_cnt_q == IN_LAST) begin
              in_cnt_q   <= '0;
              state_q    <= WAIT_SYNC;
              in_ready_q <= 1'b0;
              busy_q     <= 1'b1;
            end else begin
              in_cnt_q <= in_cnt_q + 5'd1;
            end
`endif
          end
        end
        WAIT_SYNC: begin
          // A sync seen on the last-byte edge was sampled in LOAD, so it never launches.
          if (frame_sync) begin
            state_q <= RUN;
          end
        end
        RUN: begin
          if (frame_sync) begin
            state_q <= OUT;
          end
        end
        OUT: begin
          if (ser_done) begin
            state_q    <= LOAD;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b0;
          end
        end
        default: begin
          state_q <= LOAD;
        end
      endcase
    end
  end

  present_byte_ser u_ser (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_i   (ser_load),
    .data_i   (core_result),
    .tdata_o  (out_data),
    .tvalid_o (out_valid),
    .tready_i (out_ready),
    .done_o   (ser_done)
  );

  assign in_ready   = in_ready_q;
  assign busy       = busy_q;
  assign core_state = core_state_q;
  assign core_keys  = core_keys_q;

endmodule
